// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives the pc load port and a single-outstanding imem read.
// Optional ack watchdog with sticky FetchFault is enabled by defining FETCH_TIMEOUT_EN.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Pc,
    output logic [31:0] PcData,
    output logic        PcLdEn,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemData,
    output logic [31:0] Instr,
    output logic        InstrValid,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget
`ifdef FETCH_TIMEOUT_EN
    ,
    output logic        FetchFault
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_DROP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] redirect_pc;
    logic        timeout_hit;

    assign redirect_pc = {RedirectTarget[31:2], 2'b00};

    logic unused_tgt_bits;
    assign unused_tgt_bits = ^RedirectTarget[1:0];

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          fault_q, fault_d;
    logic          req_active;

    // Derived from state_q rather than ImemReq to keep this block off the FSM's combinational path.
    assign req_active = (state_q == S_FETCH) || (state_q == S_DROP);

    always_comb begin
        cnt_d       = cnt_q;
        fault_d     = fault_q;
        timeout_hit = 1'b0;
        if (req_active && !ImemAck) begin
            if (cnt_q == CW'(TIMEOUT - 1)) begin
                timeout_hit = 1'b1;
                fault_d     = 1'b1;
                cnt_d       = '0;
            end else if (state_q == S_FETCH && Redirect) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign FetchFault = fault_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        req_addr_d = req_addr_q;
        PcLdEn     = 1'b0;
        PcData     = RESET_PC;
        ImemReq    = 1'b0;
        ImemAddr   = Pc;
        if (!Reset) begin
            case (state_q)
                S_IDLE: begin
                    PcLdEn  = 1'b1;
                    state_d = S_FETCH;
                end
                S_FETCH: begin
                    ImemReq    = 1'b1;
                    req_addr_d = Pc;
                    if (Redirect) begin
                        PcLdEn  = 1'b1;
                        PcData  = redirect_pc;
                        valid_d = 1'b0;
                        state_d = ImemAck ? S_FETCH : S_DROP;
                    end else if (ImemAck) begin
                        instr_d = ImemData;
                        valid_d = 1'b1;
                        PcLdEn  = 1'b1;
                        PcData  = Pc + 32'd4;
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (Redirect) begin
                        PcLdEn  = 1'b1;
                        PcData  = redirect_pc;
                        valid_d = 1'b0;
                        state_d = S_FETCH;
                    end else if (!Stall) begin
                        valid_d = 1'b0;
                        state_d = S_FETCH;
                    end
                end
                S_DROP: begin
                    ImemReq  = 1'b1;
                    ImemAddr = req_addr_q;
                    if (Redirect) begin
                        PcLdEn  = 1'b1;
                        PcData  = redirect_pc;
                        valid_d = 1'b0;
                    end
                    // A coincident ack still retires the stale read, so never wait for a second one.
                    if (ImemAck) begin
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (timeout_hit) begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                PcLdEn  = 1'b0;
                PcData  = RESET_PC;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            req_addr_q <= req_addr_d;
        end
    end

    assign Instr      = instr_q;
    assign InstrValid = valid_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed table-driven bench for fetch_ctrl with a behavioural pc register.
// Watchdog sequence is compiled in when FETCH_TIMEOUT_EN is defined.
module tb_fetch_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] PcData;
    logic        PcLdEn;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemData;
    logic [31:0] Instr;
    logic        InstrValid;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectTarget;
`ifdef FETCH_TIMEOUT_EN
    logic        FetchFault;
`endif

    logic [31:0] pc_m = 32'hDEAD_BEE0;

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (PcLdEn === 1'b1) pc_m <= PcData;
    end

    fetch_ctrl #(
        .RESET_PC(32'h0000_0000),
        .TIMEOUT (16)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Pc            (pc_m),
        .PcData        (PcData),
        .PcLdEn        (PcLdEn),
        .ImemReq       (ImemReq),
        .ImemAddr      (ImemAddr),
        .ImemAck       (ImemAck),
        .ImemData      (ImemData),
        .Instr         (Instr),
        .InstrValid    (InstrValid),
        .Stall         (Stall),
        .Redirect      (Redirect),
        .RedirectTarget(RedirectTarget)
`ifdef FETCH_TIMEOUT_EN
        ,
        .FetchFault    (FetchFault)
`endif
    );

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] data;
        logic        stall;
        logic        redir;
        logic [31:0] tgt;
        logic        e_ld;
        logic [31:0] e_pcd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    localparam int NV = 29;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic ack, input logic [31:0] data,
                         input logic stall, input logic redir, input logic [31:0] tgt);
        @(negedge Clk);
        Reset          = rst;
        ImemAck        = ack;
        ImemData       = data;
        Stall          = stall;
        Redirect       = redir;
        RedirectTarget = tgt;
        #2;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        Reset          = 1'b1;
        ImemAck        = 1'b0;
        ImemData       = 32'h0;
        Stall          = 1'b0;
        Redirect       = 1'b0;
        RedirectTarget = 32'h0;

        //          rst   ack   data          stall redir tgt            ld    pcdata        req   addr          valid instr         pc
        vt[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'hDEAD_BEE0};
        vt[1]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'hDEAD_BEE0};
        vt[2]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'hDEAD_BEE0};
        vt[3]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'hDEAD_BEE0};
        vt[4]  = '{1'b0, 1'b1, 32'h2008_0005, 1'b0, 1'b0, 32'h0,       1'b1, 32'h4,        1'b1, 32'h0,        1'b0, 32'h0,        32'h0};
        vt[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h2008_0005, 32'h4};
        vt[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h2008_0005, 32'h4};
        vt[7]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h2008_0005, 32'h4};
        vt[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h2008_0005, 32'h4};
        vt[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h4,        1'b0, 32'h0,        32'h4};
        vt[10] = '{1'b0, 1'b1, 32'h0000_1111, 1'b0, 1'b0, 32'h0,       1'b1, 32'h8,        1'b1, 32'h4,        1'b0, 32'h0,        32'h4};
        vt[11] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_1111, 32'h8};
        vt[12] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h103,      1'b1, 32'h100,      1'b1, 32'h8,        1'b0, 32'h0,        32'h8};
        vt[13] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h8,        1'b0, 32'h0,        32'h100};
        vt[14] = '{1'b0, 1'b1, 32'h0000_0BAD, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 32'h8,        1'b0, 32'h0,        32'h100};
        vt[15] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h100,      1'b0, 32'h0,        32'h100};
        vt[16] = '{1'b0, 1'b1, 32'h0000_BAD2, 1'b0, 1'b1, 32'h40,      1'b1, 32'h40,       1'b1, 32'h100,      1'b0, 32'h0,        32'h100};
        vt[17] = '{1'b0, 1'b1, 32'h0000_3333, 1'b0, 1'b0, 32'h0,       1'b1, 32'h44,       1'b1, 32'h40,       1'b0, 32'h0,        32'h40};
        vt[18] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,      1'b1, 32'h0000_3333, 32'h44};
        vt[19] = '{1'b0, 1'b1, 32'h0000_4444, 1'b0, 1'b0, 32'h0,       1'b1, 32'h0,        1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,       32'hFFFF_FFFC};
        vt[20] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_4444, 32'h0};
        vt[21] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h200,      1'b1, 32'h200,      1'b1, 32'h0,        1'b0, 32'h0,        32'h0};
        vt[22] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h300,      1'b1, 32'h300,      1'b1, 32'h0,        1'b0, 32'h0,        32'h200};
        vt[23] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0000_4444, 32'h300};
        vt[24] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h500,      1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h300};
        vt[25] = '{1'b0, 1'b1, 32'h0000_5555, 1'b0, 1'b0, 32'h0,       1'b1, 32'h4,        1'b1, 32'h0,        1'b0, 32'h0,        32'h0};
        vt[26] = '{1'b0, 1'b1, 32'h0000_6666, 1'b1, 1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_5555, 32'h4};
        vt[27] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_5555, 32'h4};
        vt[28] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h4,        1'b0, 32'h0,        32'h4};

        for (int i = 0; i < NV; i++) begin
            drive(vt[i].rst, vt[i].ack, vt[i].data, vt[i].stall, vt[i].redir, vt[i].tgt);
            $display("[TB] vec %0d rst=%b ack=%b stall=%b redir=%b -> ld=%b pcdata=%08h req=%b addr=%08h valid=%b instr=%08h pc=%08h",
                     i, vt[i].rst, vt[i].ack, vt[i].stall, vt[i].redir, PcLdEn, PcData, ImemReq, ImemAddr,
                     InstrValid, Instr, pc_m);
            chk($sformatf("v%0d PcLdEn", i), {31'b0, PcLdEn}, {31'b0, vt[i].e_ld});
            if (vt[i].e_ld || vt[i].rst) chk($sformatf("v%0d PcData", i), PcData, vt[i].e_pcd);
            chk($sformatf("v%0d ImemReq", i), {31'b0, ImemReq}, {31'b0, vt[i].e_req});
            if (vt[i].e_req) chk($sformatf("v%0d ImemAddr", i), ImemAddr, vt[i].e_addr);
            chk($sformatf("v%0d InstrValid", i), {31'b0, InstrValid}, {31'b0, vt[i].e_valid});
            if (vt[i].e_valid || vt[i].rst) chk($sformatf("v%0d Instr", i), Instr, vt[i].e_instr);
            chk($sformatf("v%0d Pc", i), pc_m, vt[i].e_pc);
        end

        // Long wait for ack: request and address must stay frozen.
        for (int k = 0; k < 5; k++) begin
            idle_cycle();
            $display("[TB] wait %0d req=%b addr=%08h", k, ImemReq, ImemAddr);
            chk($sformatf("wait%0d ImemReq", k), {31'b0, ImemReq}, 32'h1);
            chk($sformatf("wait%0d ImemAddr", k), ImemAddr, 32'h4);
            chk($sformatf("wait%0d PcLdEn", k), {31'b0, PcLdEn}, 32'h0);
        end
        drive(1'b0, 1'b1, 32'h0000_7777, 1'b0, 1'b0, 32'h0);
        $display("[TB] late ack ld=%b pcdata=%08h", PcLdEn, PcData);
        chk("late_ack PcLdEn", {31'b0, PcLdEn}, 32'h1);
        chk("late_ack PcData", PcData, 32'h8);
        idle_cycle();
        $display("[TB] late hold valid=%b instr=%08h pc=%08h", InstrValid, Instr, pc_m);
        chk("late_hold InstrValid", {31'b0, InstrValid}, 32'h1);
        chk("late_hold Instr", Instr, 32'h0000_7777);
        chk("late_hold Pc", pc_m, 32'h8);
        chk("late_hold ImemReq", {31'b0, ImemReq}, 32'h0);

`ifdef FETCH_TIMEOUT_EN
        for (int k = 0; k < 16; k++) begin
            idle_cycle();
            $display("[TB] noack %0d req=%b fault=%b", k, ImemReq, FetchFault);
            chk($sformatf("noack%0d ImemReq", k), {31'b0, ImemReq}, 32'h1);
            chk($sformatf("noack%0d FetchFault", k), {31'b0, FetchFault}, 32'h0);
        end
        idle_cycle();
        $display("[TB] timeout req=%b fault=%b ld=%b pcdata=%08h", ImemReq, FetchFault, PcLdEn, PcData);
        chk("timeout FetchFault", {31'b0, FetchFault}, 32'h1);
        chk("timeout ImemReq", {31'b0, ImemReq}, 32'h0);
        chk("timeout PcLdEn", {31'b0, PcLdEn}, 32'h1);
        chk("timeout PcData", PcData, 32'h0);
        idle_cycle();
        $display("[TB] refetch req=%b addr=%08h fault=%b", ImemReq, ImemAddr, FetchFault);
        chk("refetch ImemReq", {31'b0, ImemReq}, 32'h1);
        chk("refetch ImemAddr", ImemAddr, 32'h0);
        chk("refetch FetchFault", {31'b0, FetchFault}, 32'h1);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("fault_rst ImemReq", {31'b0, ImemReq}, 32'h0);
        idle_cycle();
        $display("[TB] after reset fault=%b", FetchFault);
        chk("fault_clear FetchFault", {31'b0, FetchFault}, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer that owns the program-counter register's load port and the instruction-memory read handshake. Each cycle it chooses the next PC: reset vector, PC+4, or a redirect target from branch/jump resolution. It issues one outstanding imem read at a time and holds the fetched instruction until decode accepts it. It sits between the pc register, the instruction memory and the decode stage.

Parameters:
RESET_PC, 32'h0000_0000, vector loaded into pc on leaving reset; low 2 bits must be 0
TIMEOUT, 16, ack watchdog limit in cycles; used only with FETCH_TIMEOUT_EN

Ports:
Clk  in  1  rising-edge clock
Reset  in  1  synchronous, active-high reset
Pc  in  32  current pc register value (pc Dout)
PcData  out  32  next-PC value to pc Data
PcLdEn  out  1  pc load enable
ImemReq  out  1  imem read request
ImemAddr  out  32  imem read address
ImemAck  in  1  imem read data valid, 1-cycle pulse
ImemData  in  32  imem read data
Instr  out  32  fetched instruction (registered)
InstrValid  out  1  Instr valid toward decode
Stall  in  1  decode cannot accept Instr this cycle
Redirect  in  1  taken branch or jump, 1-cycle pulse
RedirectTarget  in  32  new PC; bits [1:0] ignored, forced to 0
FetchFault  out  1  sticky watchdog fault; port present only with FETCH_TIMEOUT_EN

Behaviour:
- Clk and Reset are the only clock and reset. Reset is synchronous and active-high, with priority over all other inputs.
- While Reset is high: state=IDLE, PcLdEn=0, PcData=RESET_PC, ImemReq=0, InstrValid=0, Instr=0, internal ReqAddr=0, FetchFault=0.
- Outputs PcLdEn, PcData, ImemReq and ImemAddr are combinational from state and inputs. Instr, InstrValid and state are registered.
- States and required behaviour:
  - IDLE: PcLdEn=1, PcData=RESET_PC. Next state FETCH.
  - FETCH: ImemReq=1, ImemAddr=Pc, ReqAddr<=Pc each cycle.
    - On ImemAck: Instr<=ImemData, InstrValid<=1, PcLdEn=1, PcData=Pc+4, then HOLD.
    - Without ack: stay in FETCH.
  - HOLD: InstrValid=1, ImemReq=0.
    - Stall=0: decode consumes Instr this cycle; InstrValid<=0, then FETCH.
    - Stall=1: stay in HOLD; Instr and Pc unchanged.
  - DROP: a request is outstanding but its data is stale. ImemReq=1, ImemAddr=ReqAddr (frozen).
    - On ImemAck: data discarded, InstrValid stays 0, then FETCH.
- Redirect has priority over sequential PC update and over Stall, in any state except IDLE.
  - Required actions: PcLdEn=1, PcData={RedirectTarget[31:2],2'b00}, InstrValid<=0.
  - FETCH without ack -> DROP.
  - FETCH with ack in the same cycle -> ImemData discarded, go to FETCH.
  - HOLD -> held instruction dropped, go to FETCH.
  - DROP -> stay in DROP with the new target; ReqAddr is unchanged.
  - Redirect in IDLE is ignored.
- Handshake rules:
  - Once ImemReq rises, it and ImemAddr stay constant until the ImemAck cycle.
  - At most one request is outstanding.
  - ImemReq drops in the cycle after the ack, at the earliest.
- Latency: the minimum fetch-to-fetch interval is 2 cycles (FETCH with ack, then HOLD with Stall=0).
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 = 0.
- ImemAck outside FETCH/DROP is ignored.
- Reset mid-request abandons the outstanding read with no wait for ack. The memory tolerates the dropped request.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined: a counter clears on entry to FETCH/DROP and increments each cycle ImemReq=1 without ImemAck.
  - When the counter reaches TIMEOUT: FetchFault<=1 (sticky until Reset), ImemReq deasserts, state->IDLE, InstrValid<=0.
  - The IDLE re-entry reloads RESET_PC.
- Undefined: no counter and no FetchFault port; the controller waits indefinitely for ack.

Test Plan:
- Reset high 3 cycles, then low; ack in the first FETCH cycle with ImemData=32'h2008_0005 -> IDLE cycle shows PcLdEn=1, PcData=0; FETCH shows ImemAddr=0; next cycle Instr=32'h2008_0005, InstrValid=1, Pc=4.
- In HOLD, Stall=1 for 3 cycles then 0 -> InstrValid=1 for 4 cycles, ImemReq=0 and Pc=4 throughout; the following FETCH has ImemAddr=4.
- In FETCH at Pc=8, no ack, Redirect=1 with RedirectTarget=32'h0000_0103 -> PcData=32'h100, state DROP, ImemAddr stays 8; ack 2 cycles later is discarded with InstrValid=0; next FETCH has ImemAddr=32'h100.
- Redirect and ImemAck in the same FETCH cycle, target 32'h40 -> Instr not captured, InstrValid=0, next FETCH ImemAddr=32'h40; Redirect plus Stall=1 in HOLD -> instruction dropped, FETCH at the target.
- Pc=32'hFFFF_FFFC fetch acked -> PcData=0. Reset asserted in DROP -> ImemReq=0 the next cycle, then IDLE reloads RESET_PC.
- With FETCH_TIMEOUT_EN and TIMEOUT=16, no ack for 16 cycles -> FetchFault=1 and ImemReq=0, then IDLE and FETCH at RESET_PC; FetchFault stays 1 until Reset.
